// File: rtl/excep_req_gen.sv
// excep_req_gen: exception requester. Picks the highest-priority pipeline
// exception source, captures it with its PC and data address, holds the
// request until the controller acknowledges, then pulses flush for one cycle.
module excep_req_gen #(
  parameter int CODE_W  = 4,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isFetchIn,
  input  logic              isUndefinedIn,
  input  logic              isPrivelegedIn,
  input  logic              isTrapedIn,
  input  logic              scIn,
  input  logic              isLoadIn,
  input  logic              isStoreIn,
  input  logic              extIntIn,
  input  logic              msrEE,
  input  logic [ADDR_W-1:0] pcIn,
  input  logic [ADDR_W-1:0] dataAddrIn,
  input  logic              ack,
  output logic [CODE_W-1:0] excepCode,
  output logic [ADDR_W-1:0] excepPC,
  output logic [ADDR_W-1:0] excepDAR,
  output logic              stall,
  output logic              flush,
  output logic              ackTimeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CODE_W-1:0] CODE_NONE   = CODE_W'(0);
  localparam logic [CODE_W-1:0] CODE_ISI    = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_ILL    = CODE_W'(2);
  localparam logic [CODE_W-1:0] CODE_PRIV   = CODE_W'(3);
  localparam logic [CODE_W-1:0] CODE_TRAP   = CODE_W'(4);
  localparam logic [CODE_W-1:0] CODE_SC     = CODE_W'(5);
  localparam logic [CODE_W-1:0] CODE_DSI_LD = CODE_W'(6);
  localparam logic [CODE_W-1:0] CODE_DSI_ST = CODE_W'(7);
  localparam logic [CODE_W-1:0] CODE_EXT    = CODE_W'(8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, stateNext;
  logic              extGated;
  logic              anySrc;
  logic              isDsi;
  logic [CODE_W-1:0] srcCode;
  logic [CNT_W-1:0]  toCnt;

  assign extGated = extIntIn & msrEE;
  assign anySrc   = isFetchIn | isUndefinedIn | isPrivelegedIn | isTrapedIn |
                    scIn | isLoadIn | isStoreIn | extGated;
  assign isDsi    = (srcCode == CODE_DSI_LD) || (srcCode == CODE_DSI_ST);

  // Fixed-priority encoder over the exception sources
  always_comb begin
    srcCode = CODE_NONE;
    if (isFetchIn)           srcCode = CODE_ISI;
    else if (isUndefinedIn)  srcCode = CODE_ILL;
    else if (isPrivelegedIn) srcCode = CODE_PRIV;
    else if (isTrapedIn)     srcCode = CODE_TRAP;
    else if (scIn)           srcCode = CODE_SC;
    else if (isLoadIn)       srcCode = CODE_DSI_LD;
    else if (isStoreIn)      srcCode = CODE_DSI_ST;
    else if (extGated)       srcCode = CODE_EXT;
  end

  // Next-state logic and combinational stall (freezes pipeline in detect cycle)
  always_comb begin
    stateNext = state;
    stall     = 1'b1;
    case (state)
      IDLE: begin
        stall = anySrc;
        if (anySrc) stateNext = REQ;
      end
      REQ:  if (ack)  stateNext = DONE;
      DONE: if (!ack) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Capture of code/PC/DAR, flush pulse on acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      excepCode <= CODE_NONE;
      excepPC   <= '0;
      excepDAR  <= '0;
      flush     <= 1'b0;
    end else begin
      flush <= 1'b0;
      if (state == IDLE && anySrc) begin
        excepCode <= srcCode;
        excepPC   <= pcIn;
        excepDAR  <= isDsi ? dataAddrIn : '0;
      end else if (state == REQ && ack) begin
        excepCode <= CODE_NONE;
        flush     <= 1'b1;
      end
    end
  end

  // Ack-overdue counter: restarts on capture, saturates, sticky flag until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      toCnt      <= '0;
      ackTimeout <= 1'b0;
    end else if (state == IDLE && anySrc) begin
      toCnt <= '0;
    end else if (state == REQ) begin
      if (toCnt != CNT_W'(TIMEOUT)) toCnt <= toCnt + 1'b1;
      if (toCnt == CNT_W'(TIMEOUT - 1)) ackTimeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_excep_req_gen.sv
// Directed bench for excep_req_gen: a vector table for the basic handshake
// and priority cases, then hand-written multi-cycle sequences.
module tb_excep_req_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        isFetchIn, isUndefinedIn, isPrivelegedIn, isTrapedIn;
  logic        scIn, isLoadIn, isStoreIn, extIntIn, msrEE;
  logic [31:0] pcIn, dataAddrIn;
  logic        ack;
  logic [3:0]  excepCode;
  logic [31:0] excepPC, excepDAR;
  logic        stall, flush, ackTimeout;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  excep_req_gen #(.CODE_W(4), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .isFetchIn(isFetchIn), .isUndefinedIn(isUndefinedIn),
    .isPrivelegedIn(isPrivelegedIn), .isTrapedIn(isTrapedIn),
    .scIn(scIn), .isLoadIn(isLoadIn), .isStoreIn(isStoreIn),
    .extIntIn(extIntIn), .msrEE(msrEE),
    .pcIn(pcIn), .dataAddrIn(dataAddrIn), .ack(ack),
    .excepCode(excepCode), .excepPC(excepPC), .excepDAR(excepDAR),
    .stall(stall), .flush(flush), .ackTimeout(ackTimeout)
  );

  // src bits: 0 fetch, 1 undef, 2 priv, 3 trap, 4 sc, 5 load, 6 store, 7 ext
  typedef struct {
    logic [7:0]  src;
    logic        ee;
    logic [31:0] pc;
    logic [31:0] dar;
    logic        ack;
    logic        expStall;
    logic [3:0]  expCode;
    logic [31:0] expPC;
    logic [31:0] expDAR;
    logic        expFlush;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setIn(input logic [7:0] src, input logic ee, input logic [31:0] pc,
                       input logic [31:0] dar, input logic a);
    isFetchIn      = src[0];
    isUndefinedIn  = src[1];
    isPrivelegedIn = src[2];
    isTrapedIn     = src[3];
    scIn           = src[4];
    isLoadIn       = src[5];
    isStoreIn      = src[6];
    extIntIn       = src[7];
    msrEE          = ee;
    pcIn           = pc;
    dataAddrIn     = dar;
    ack            = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b0, 4'd0, 32'h000, 32'h0000, 1'b0};
    vecs[1]  = '{8'h02, 1'b0, 32'h100, 32'h0000, 1'b0, 1'b1, 4'd2, 32'h100, 32'h0000, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b1, 4'd2, 32'h100, 32'h0000, 1'b0};
    vecs[3]  = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b1, 1'b1, 4'd0, 32'h100, 32'h0000, 1'b1};
    vecs[4]  = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b1, 4'd0, 32'h100, 32'h0000, 1'b0};
    vecs[5]  = '{8'h31, 1'b0, 32'h200, 32'hBEEF, 1'b0, 1'b1, 4'd1, 32'h200, 32'h0000, 1'b0};
    vecs[6]  = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b1, 1'b1, 4'd0, 32'h200, 32'h0000, 1'b1};
    vecs[7]  = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b1, 4'd0, 32'h200, 32'h0000, 1'b0};
    vecs[8]  = '{8'h20, 1'b0, 32'h300, 32'hBEEF, 1'b0, 1'b1, 4'd6, 32'h300, 32'hBEEF, 1'b0};
    vecs[9]  = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b1, 1'b1, 4'd0, 32'h300, 32'hBEEF, 1'b1};
    vecs[10] = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b1, 4'd0, 32'h300, 32'hBEEF, 1'b0};
    vecs[11] = '{8'h80, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b0, 4'd0, 32'h300, 32'hBEEF, 1'b0};
    vecs[12] = '{8'h80, 1'b1, 32'h400, 32'h1234, 1'b0, 1'b1, 4'd8, 32'h400, 32'h0000, 1'b0};
    vecs[13] = '{8'h80, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b1, 4'd8, 32'h400, 32'h0000, 1'b0};
    vecs[14] = '{8'h80, 1'b0, 32'h000, 32'h0000, 1'b1, 1'b1, 4'd0, 32'h400, 32'h0000, 1'b1};
    vecs[15] = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b1, 4'd0, 32'h400, 32'h0000, 1'b0};
    vecs[16] = '{8'h40, 1'b0, 32'h700, 32'hCAFE, 1'b0, 1'b1, 4'd7, 32'h700, 32'hCAFE, 1'b0};
    vecs[17] = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b1, 1'b1, 4'd0, 32'h700, 32'hCAFE, 1'b1};
    vecs[18] = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b1, 4'd0, 32'h700, 32'hCAFE, 1'b0};
    vecs[19] = '{8'h18, 1'b0, 32'h800, 32'h5555, 1'b0, 1'b1, 4'd4, 32'h800, 32'h0000, 1'b0};
    vecs[20] = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b1, 1'b1, 4'd0, 32'h800, 32'h0000, 1'b1};
    vecs[21] = '{8'h00, 1'b0, 32'h000, 32'h0000, 1'b0, 1'b1, 4'd0, 32'h800, 32'h0000, 1'b0};

    // Reset state
    rst = 1'b1;
    setIn(8'h00, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    rst = 1'b0;
    check("rst_code", 32'(excepCode), 32'd0);
    check("rst_pc", excepPC, 32'h0);
    check("rst_dar", excepDAR, 32'h0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_to", 32'(ackTimeout), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 22; i++) begin
      setIn(vecs[i].src, vecs[i].ee, vecs[i].pc, vecs[i].dar, vecs[i].ack);
      #1;
      check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].expStall));
      step();
      check($sformatf("v%0d_code", i), 32'(excepCode), 32'(vecs[i].expCode));
      check($sformatf("v%0d_pc", i), excepPC, vecs[i].expPC);
      check($sformatf("v%0d_dar", i), excepDAR, vecs[i].expDAR);
      check($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].expFlush));
      check($sformatf("v%0d_to", i), 32'(ackTimeout), 32'd0);
    end

    // Ack held through DONE while TRAP is pending: no capture until ack drops
    setIn(8'h10, 1'b0, 32'h500, 32'h0, 1'b0);
    step();
    check("hold_sc_code", 32'(excepCode), 32'd5);
    setIn(8'h08, 1'b0, 32'h510, 32'h0, 1'b1);
    step();
    check("hold_ack_code", 32'(excepCode), 32'd0);
    check("hold_ack_flush", 32'(flush), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("hold_done%0d_code", k), 32'(excepCode), 32'd0);
      check($sformatf("hold_done%0d_flush", k), 32'(flush), 32'd0);
      check($sformatf("hold_done%0d_stall", k), 32'(stall), 32'd1);
    end
    ack = 1'b0;
    step();
    check("hold_idle_code", 32'(excepCode), 32'd0);
    step();
    check("hold_trap_code", 32'(excepCode), 32'd4);
    check("hold_trap_pc", excepPC, 32'h510);
    setIn(8'h00, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check("hold_trap_flush", 32'(flush), 32'd1);
    ack = 1'b0;
    step();

    // Ack timeout with TIMEOUT=4
    setIn(8'h04, 1'b0, 32'h600, 32'h0, 1'b0);
    step();
    check("to_code", 32'(excepCode), 32'd3);
    setIn(8'h00, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("to_pre%0d", k), 32'(ackTimeout), 32'd0);
    end
    step();
    check("to_set", 32'(ackTimeout), 32'd1);
    check("to_code_held", 32'(excepCode), 32'd3);
    step();
    step();
    check("to_sat", 32'(ackTimeout), 32'd1);
    check("to_sat_code", 32'(excepCode), 32'd3);
    ack = 1'b1;
    step();
    check("to_ack_flush", 32'(flush), 32'd1);
    check("to_ack_code", 32'(excepCode), 32'd0);
    check("to_ack_sticky", 32'(ackTimeout), 32'd1);
    ack = 1'b0;
    step();
    check("to_idle_sticky", 32'(ackTimeout), 32'd1);

    // Reset in REQ with code 5
    setIn(8'h10, 1'b0, 32'h900, 32'h0, 1'b0);
    step();
    check("rreq_code", 32'(excepCode), 32'd5);
    setIn(8'h00, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rreq_code0", 32'(excepCode), 32'd0);
    check("rreq_flush", 32'(flush), 32'd0);
    check("rreq_to", 32'(ackTimeout), 32'd0);
    check("rreq_stall", 32'(stall), 32'd0);

    // Source coinciding with reset is not captured
    rst = 1'b1;
    setIn(8'h01, 1'b0, 32'hA00, 32'h0, 1'b0);
    step();
    rst = 1'b0;
    setIn(8'h00, 1'b0, 32'h0, 32'h0, 1'b0);
    check("rsrc_code", 32'(excepCode), 32'd0);
    check("rsrc_pc", excepPC, 32'h0);
    step();
    check("rsrc_code_after", 32'(excepCode), 32'd0);
    check("rsrc_stall", 32'(stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
